// File: rtl/can_crc_pkg.sv
// Shared types and constants for the CAN CRC-15 arbiter.
package can_crc_pkg;

    localparam int          CRC15_WIDTH  = 15;
    localparam int          BEAT_WIDTH   = 64;
    localparam logic [14:0] CRC15_POLY   = 15'h4599;
    localparam logic [14:0] CRC_INIT_DEF = 15'h7FFF;

    typedef enum logic {
        OWN_TX = 1'b0,
        OWN_RX = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/can_crc15_step64.sv
// One 64-bit beat of CAN CRC-15 (x^15+x^14+x^10+x^8+x^7+x^4+x^3+1),
// MSB of the beat first, unrolled from the serial CAN shift register.
module can_crc15_step64
    import can_crc_pkg::*;
(
    input  logic [CRC15_WIDTH-1:0] crc_i,
    input  logic [BEAT_WIDTH-1:0]  data_i,
    output logic [CRC15_WIDTH-1:0] crc_o
);

    logic [CRC15_WIDTH-1:0] c;
    logic                   fb;

    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int i = BEAT_WIDTH - 1; i >= 0; i--) begin
            fb = data_i[i] ^ c[CRC15_WIDTH-1];
            c  = {c[CRC15_WIDTH-2:0], 1'b0};
            if (fb) c = c ^ CRC15_POLY;
        end
        crc_o = c;
    end

endmodule

// File: rtl/can_crc_arbiter.sv
// Round-robin share of one CRC-15 engine between TX builder and RX checker.
// Optional idle-beat watchdog enabled by defining CRC_TIMEOUT_EN.
module can_crc_arbiter
    import can_crc_pkg::*;
#(
    parameter int          MAX_BEATS   = 4,
    parameter logic [14:0] CRC_INIT    = CRC_INIT_DEF,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [BEAT_WIDTH-1:0]  tx_data,
    input  logic                   tx_last,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic [BEAT_WIDTH-1:0]  rx_data,
    input  logic                   rx_last,
    input  logic [CRC15_WIDTH-1:0] rx_crc_ref,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_owner,
    output logic [CRC15_WIDTH-1:0] res_crc,
    output logic [7:0]             res_beats,
    output logic                   res_crc_ok,
    output logic                   res_overflow,
    output logic                   res_timeout
);

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_e                 state_q, state_d;
    owner_e                 owner_q, owner_d;
    owner_e                 prio_q, prio_d;
    logic [CRC15_WIDTH-1:0] crc_q, crc_d, crc_nxt;
    logic [7:0]             beats_q, beats_d;
    logic                   ovf_q, ovf_d;
    logic                   ok_q, ok_d;

    logic                   sel_valid, sel_last;
    logic [BEAT_WIDTH-1:0]  sel_data;
    logic                   done;

`ifdef CRC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          tmo_q, tmo_d;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign sel_valid = (owner_q == OWN_TX) ? tx_valid : rx_valid;
    assign sel_last  = (owner_q == OWN_TX) ? tx_last  : rx_last;
    assign sel_data  = (owner_q == OWN_TX) ? tx_data  : rx_data;

    can_crc15_step64 u_step (
        .crc_i  (crc_q),
        .data_i (sel_data),
        .crc_o  (crc_nxt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        crc_d   = crc_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;
        ok_d    = ok_q;
`ifdef CRC_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_valid || rx_valid) begin
                    if (tx_valid && rx_valid) owner_d = prio_q;
                    else                      owner_d = tx_valid ? OWN_TX : OWN_RX;
                    crc_d   = CRC_INIT;
                    beats_d = '0;
                    ovf_d   = 1'b0;
                    ok_d    = 1'b0;
`ifdef CRC_TIMEOUT_EN
                    idle_cnt_d = '0;
                    tmo_d      = 1'b0;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sel_valid) begin
                    crc_d   = crc_nxt;
                    beats_d = beats_q + 8'd1;
`ifdef CRC_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (sel_last) begin
                        // Compare registered on the last beat so it is ready with res_valid.
                        ok_d    = (owner_q == OWN_RX) && (crc_nxt == rx_crc_ref);
                        state_d = ST_DONE;
                    end else if (beats_q + 8'd1 == MAX_B) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`ifdef CRC_TIMEOUT_EN
                else if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (res_ready) begin
                    prio_d  = (owner_q == OWN_TX) ? OWN_RX : OWN_TX;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_TX;
            prio_q  <= OWN_TX;
            crc_q   <= CRC_INIT;
            beats_q <= '0;
            ovf_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            crc_q   <= crc_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
            ok_q    <= ok_d;
        end
    end

`ifdef CRC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            tmo_q      <= tmo_d;
        end
    end
`endif

    // Result fields read as zero outside DONE so reset and idle look identical.
    assign done         = (state_q == ST_DONE);
    assign tx_ready     = (state_q == ST_RUN) && (owner_q == OWN_TX);
    assign rx_ready     = (state_q == ST_RUN) && (owner_q == OWN_RX);
    assign res_valid    = done;
    assign res_owner    = done && (owner_q == OWN_RX);
    assign res_crc      = done ? crc_q : '0;
    assign res_beats    = done ? beats_q : '0;
    assign res_crc_ok   = done && ok_q;
    assign res_overflow = done && ovf_q;
`ifdef CRC_TIMEOUT_EN
    assign res_timeout  = done && tmo_q;
`else
    assign res_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_can_crc_arbiter.sv
// Directed bench for can_crc_arbiter; CRC expectations come from a polynomial long-division model.
module tb_can_crc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid, tx_last, rx_valid, rx_last, res_ready;
    logic [63:0] tx_data, rx_data;
    logic [14:0] rx_crc_ref;
    logic        tx_ready, rx_ready, res_valid, res_owner, res_crc_ok, res_overflow, res_timeout;
    logic [14:0] res_crc;
    logic [7:0]  res_beats;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    can_crc_arbiter #(.MAX_BEATS(4), .CRC_INIT(15'h7FFF), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
        .rx_crc_ref(rx_crc_ref),
        .res_valid(res_valid), .res_ready(res_ready), .res_owner(res_owner), .res_crc(res_crc),
        .res_beats(res_beats), .res_crc_ok(res_crc_ok), .res_overflow(res_overflow),
        .res_timeout(res_timeout)
    );

    // (crc * x^64 + data * x^15) mod P, computed by long division.
    function automatic logic [14:0] crc_model(input logic [14:0] c, input logic [63:0] d);
        logic [78:0] v;
        v = {c, 64'b0} ^ {d, 15'b0};
        for (int i = 78; i >= 15; i--)
            if (v[i]) v[i -: 16] = v[i -: 16] ^ 16'hC599;
        return v[14:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait for the edge that accepts it.
    task automatic send(input logic own, input logic [63:0] d, input logic l, input logic [14:0] r);
        int n = 0;
        if (!own) begin tx_valid = 1; tx_data = d; tx_last = l; end
        else      begin rx_valid = 1; rx_data = d; rx_last = l; rx_crc_ref = r; end
        while (((own ? rx_ready : tx_ready) == 1'b0) && n < 20) begin step(); n++; end
        chk("ready_wait", 64'(n < 20), 64'd1);
        step();
        if (!own) tx_valid = 0; else rx_valid = 0;
    endtask

    task automatic consume();
        res_ready = 1;
        step();
        res_ready = 0;
        chk("res_drop", 64'(res_valid), 64'd0);
    endtask

    logic [14:0] g, g2;
    logic [63:0] ov [5];
    int          n;

    initial begin
        rst = 1; tx_valid = 0; tx_last = 0; tx_data = '0;
        rx_valid = 0; rx_last = 0; rx_data = '0; rx_crc_ref = '0; res_ready = 0;
        step(); step();
        chk("rst_tx_ready", 64'(tx_ready), 0);
        chk("rst_rx_ready", 64'(rx_ready), 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_crc", 64'(res_crc), 0);
        chk("rst_res_beats", 64'(res_beats), 0);
        rst = 0;
        step();

        // TX single zero beat
        tx_valid = 1; tx_data = 64'h0; tx_last = 1;
        chk("tx_idle_noready", 64'(tx_ready), 0);
        send(0, 64'h0, 1, 0);
        g = crc_model(15'h7FFF, 64'h0);
        chk("tx1_valid", 64'(res_valid), 1);
        chk("tx1_owner", 64'(res_owner), 0);
        chk("tx1_beats", 64'(res_beats), 1);
        chk("tx1_crc", 64'(res_crc), 64'(g));
        chk("tx1_ok", 64'(res_crc_ok), 0);
        chk("tx1_ovf", 64'(res_overflow), 0);
        chk("tx1_tmo", 64'(res_timeout), 0);
        step(); step();
        chk("tx1_hold_valid", 64'(res_valid), 1);
        chk("tx1_hold_crc", 64'(res_crc), 64'(g));
        consume();

        // RX 3-beat, good then bad reference
        g = crc_model(crc_model(crc_model(15'h7FFF, 64'h0123456789ABCDEF), 64'hFFFF0000FFFF0000), 64'h1);
        for (int k = 0; k < 2; k++) begin
            send(1, 64'h0123456789ABCDEF, 0, 0);
            send(1, 64'hFFFF0000FFFF0000, 0, 0);
            send(1, 64'h1, 1, (k == 0) ? g : (g ^ 15'h1));
            chk("rx3_owner", 64'(res_owner), 1);
            chk("rx3_beats", 64'(res_beats), 3);
            chk("rx3_crc", 64'(res_crc), 64'(g));
            chk("rx3_ok", 64'(res_crc_ok), (k == 0) ? 64'd1 : 64'd0);
            consume();
        end

        // Contested rounds: TX, then RX, then TX again
        for (int k = 0; k < 2; k++) begin
            tx_valid = 1; tx_last = 1; tx_data = 64'hA5A5_0000_0000_5A5A + 64'(k);
            rx_valid = 1; rx_last = 1; rx_data = 64'hDEAD_BEEF_0000_0001 + 64'(k);
            rx_crc_ref = crc_model(15'h7FFF, rx_data);
            step();
            chk("cont_tx_ready", 64'(tx_ready), 1);
            chk("cont_rx_blocked", 64'(rx_ready), 0);
            step();
            tx_valid = 0;
            chk("cont_tx_owner", 64'(res_owner), 0);
            chk("cont_tx_crc", 64'(res_crc), 64'(crc_model(15'h7FFF, tx_data)));
            chk("cont_rx_blocked_done", 64'(rx_ready), 0);
            consume();
            step();
            chk("cont_rx_ready", 64'(rx_ready), 1);
            chk("cont_tx_noready", 64'(tx_ready), 0);
            step();
            rx_valid = 0;
            chk("cont_rx_owner", 64'(res_owner), 1);
            chk("cont_rx_ok", 64'(res_crc_ok), 1);
            consume();
        end

        // Overflow at MAX_BEATS; the fifth beat opens a new frame
        ov = '{64'h1111, 64'h2222_0000, 64'h3333_0000_0000, 64'h4444_0000_0000_0000, 64'hFEDC_BA98_7654_3210};
        g = 15'h7FFF;
        for (int k = 0; k < 4; k++) begin
            send(0, ov[k], 0, 0);
            g = crc_model(g, ov[k]);
        end
        chk("ovf_valid", 64'(res_valid), 1);
        chk("ovf_flag", 64'(res_overflow), 1);
        chk("ovf_beats", 64'(res_beats), 4);
        chk("ovf_crc", 64'(res_crc), 64'(g));
        tx_valid = 1; tx_data = ov[4]; tx_last = 1;
        step();
        chk("ovf_done_noready", 64'(tx_ready), 0);
        consume();
        chk("ovf_idle_noready", 64'(tx_ready), 0);
        send(0, ov[4], 1, 0);
        chk("ovf_next_beats", 64'(res_beats), 1);
        chk("ovf_next_crc", 64'(res_crc), 64'(crc_model(15'h7FFF, ov[4])));
        chk("ovf_next_flag", 64'(res_overflow), 0);
        consume();

        // Reset during beat 2 of an RX frame
        send(1, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0);
        rx_valid = 1; rx_data = 64'h1234; rx_last = 0;
        chk("mid_rx_ready", 64'(rx_ready), 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_rx_ready", 64'(rx_ready), 0);
        chk("mid_rst_res_valid", 64'(res_valid), 0);
        chk("mid_rst_beats", 64'(res_beats), 0);
        chk("mid_rst_crc", 64'(res_crc), 0);
        rx_valid = 0;
        step();
        chk("mid_rst_no_result", 64'(res_valid), 0);
        rst = 0;
        step();
        g2 = crc_model(15'h7FFF, 64'h5555_AAAA_5555_AAAA);
        send(1, 64'h5555_AAAA_5555_AAAA, 1, g2);
        chk("post_rst_crc", 64'(res_crc), 64'(g2));
        chk("post_rst_beats", 64'(res_beats), 1);
        chk("post_rst_ok", 64'(res_crc_ok), 1);
        consume();

`ifdef CRC_TIMEOUT_EN
        // One beat, then valid low until the watchdog fires
        send(0, 64'hC0FFEE, 0, 0);
        g = crc_model(15'h7FFF, 64'hC0FFEE);
        n = 0;
        while (!res_valid && n < 30) begin step(); n++; end
        chk("tmo_cycles", 64'(n), 8);
        chk("tmo_flag", 64'(res_timeout), 1);
        chk("tmo_beats", 64'(res_beats), 1);
        chk("tmo_crc", 64'(res_crc), 64'(g));
        chk("tmo_ok", 64'(res_crc_ok), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("tmo_hold_valid", 64'(res_valid), 1);
            chk("tmo_hold_crc", 64'(res_crc), 64'(g));
            chk("tmo_hold_flag", 64'(res_timeout), 1);
            chk("tmo_hold_beats", 64'(res_beats), 1);
        end
        consume();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_crc_arbiter.md
Name: can_crc_arbiter

Overview:
- Shares one CAN CRC-15 engine between the TX frame builder and the RX frame checker.
- Each requester streams a frame as 64-bit beats over a valid/ready handshake.
- The block grants one requester per frame with round-robin fairness and seeds the CRC at frame start.
- It advances the CRC on each accepted beat and returns the 15-bit result with the owner ID, beat count and error flags.

Parameters:
- MAX_BEATS, 4: maximum beats per frame; the frame is force-terminated when this is reached without last.
- CRC_INIT, 15'h7FFF: seed loaded at frame start.
- TIMEOUT_CYC, 255: idle-beat limit in cycles; used only with CRC_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- tx_valid  in  1  TX beat valid
- tx_ready  out  1  TX beat accepted
- tx_data  in  64  TX beat data
- tx_last  in  1  final TX beat of frame
- rx_valid  in  1  RX beat valid
- rx_ready  out  1  RX beat accepted
- rx_data  in  64  RX beat data
- rx_last  in  1  final RX beat of frame
- rx_crc_ref  in  15  received CRC field; sampled with the RX last beat
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_owner  out  1  0 = TX, 1 = RX
- res_crc  out  15  final CRC
- res_beats  out  8  beats accepted in the frame
- res_crc_ok  out  1  RX only: res_crc == rx_crc_ref; 0 for TX
- res_overflow  out  1  frame hit MAX_BEATS without last
- res_timeout  out  1  frame aborted by watchdog; tied 0 without CRC_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE, crc=CRC_INIT, prio=TX, beat count 0.
  - All res_* outputs 0; tx_ready=rx_ready=0.
- IDLE:
  - Ready outputs are 0.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester indicated by prio.
  - On grant: load crc<=CRC_INIT, clear the beat count and ref register, go to RUN.
  - No beat is consumed in IDLE, so a frame's first beat is accepted no earlier than 1 cycle after its valid rises.
- RUN:
  - ready is asserted only toward the granted requester; the other ready stays 0.
  - A beat is accepted when valid & ready:
    - crc <= crc15_step64(crc, data); beat count +1.
    - For RX, rx_crc_ref is captured on the last beat.
  - Accepted beat with last=1: go to DONE.
  - Accepted beat without last, where the count reaches MAX_BEATS: go to DONE with overflow=1.
  - valid low: hold state and CRC with no change.
- DONE:
  - res_valid=1; all res_* stable while res_valid && !res_ready.
  - Ready outputs are 0.
  - Result appears the cycle after the final beat is accepted (1-cycle latency).
  - On res_ready: go to IDLE, toggle prio away from the just-served owner, drop res_valid the next cycle.
- A new frame may be granted in the IDLE cycle immediately after DONE; minimum gap between frames is 1 cycle.
- The non-granted requester waits with valid held; it is never starved, guaranteed by prio toggling.
- res_crc_ok is computed as a registered compare in DONE.
- Beat counter is 8-bit and never exceeds MAX_BEATS (MAX_BEATS ≤ 255).
- Reset asserted mid-frame: immediate return to the reset values; any partial frame is discarded and no result is emitted.

Optional Feature:
- Macro CRC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN; it clears on each accepted beat and increments while the granted valid is low.
  - On reaching TIMEOUT_CYC: go to DONE with res_timeout=1; res_crc holds the partial CRC and res_crc_ok=0.
- Undefined: no counter is built; RUN waits indefinitely; res_timeout is tied to 0.

Decomposition:
- Package can_crc_pkg holds:
  - CRC15_WIDTH=15, BEAT_WIDTH=64.
  - Owner enum {OWN_TX, OWN_RX}.
  - State enum {ST_IDLE, ST_RUN, ST_DONE}.
  - Default CRC_INIT.
- Sub-module can_crc15_step64: purely combinational next-state function for polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 over a 64-bit beat.
  - It must match the existing engine's per-beat equations bit-for-bit.
  - It is needed because the existing engine has no synchronous seed load.

Test Plan:
- TX-only frame: single beat tx_data=64'h0, tx_last=1 -> one res_valid pulse, res_owner=0, res_beats=1, res_crc equals the golden step of 7FFF over 0, res_crc_ok=0.
- RX 3-beat frame: data 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'h1; rx_crc_ref set to the golden value -> res_crc_ok=1; repeat with ref^1 -> res_crc_ok=0.
- Simultaneous tx_valid and rx_valid after reset, both with 1-beat frames -> TX granted first, then RX; rx_ready stays 0 throughout the TX frame; a third contested round goes to TX.
- MAX_BEATS=4 with a 5-beat frame and no last -> DONE after beat 4, res_overflow=1, res_beats=4; beat 5 is accepted only as the first beat of a new frame.
- rst pulsed during beat 2 of an RX frame -> outputs return to their reset values within the same cycle; the next frame's CRC starts from 7FFF.
- CRC_TIMEOUT_EN, TIMEOUT_CYC=8: one beat then valid low for 8 cycles -> res_timeout=1, res_beats=1; backpressure res_ready=0 for 5 cycles keeps all res_* stable.
